// File: rtl/swerv_nbload_cam_pkg.sv
// Shared types and constants for the non-blocking load scoreboard.
package swerv_nbload_cam_pkg;

    localparam int RV_LSU_NUM_NBLOAD = 4;
    localparam int NBLOAD_TAG_W      = $clog2(RV_LSU_NUM_NBLOAD);
    localparam int NBLOAD_CNT_W      = NBLOAD_TAG_W + 1;

    localparam logic [1:0] NB_IDLE  = 2'b00;
    localparam logic [1:0] NB_PEND  = 2'b01;
    localparam logic [1:0] NB_STALE = 2'b10;

    typedef struct packed {
        logic [1:0] state;
        logic [4:0] rd;
    } nbload_entry_t;

    // x0 is never written back, so a load targeting it is born STALE.
    function automatic logic [1:0] nb_alloc_state(input logic [4:0] rd);
        return (rd == 5'd0) ? NB_STALE : NB_PEND;
    endfunction

endpackage

// File: rtl/swerv_nbload_cam_if.sv
// LSU/decode-facing signal bundle of the NB load scoreboard.
interface swerv_nbload_cam_if
    import swerv_nbload_cam_pkg::*;
#(
    parameter int DEPTH = RV_LSU_NUM_NBLOAD,
    parameter int NWB   = 2
);
    localparam int TAG_W = $clog2(DEPTH);

    logic               alloc_valid;
    logic [4:0]         alloc_rd;
    logic               alloc_ready;
    logic [TAG_W-1:0]   alloc_tag;
    logic               kill_valid;
    logic [TAG_W-1:0]   kill_tag;
    logic               flush;
    logic [NWB-1:0]     ret_valid;
    logic [NWB*TAG_W-1:0] ret_tag;
    logic [NWB-1:0]     ret_err;
    logic [4:0]         chk_rs1;
    logic [4:0]         chk_rs2;
    logic               rs1_pend;
    logic               rs2_pend;
    logic [NWB-1:0]     wb_valid;
    logic [NWB*5-1:0]   wb_rd;
    logic [NWB*TAG_W-1:0] wb_tag;
    logic [NWB-1:0]     wb_err;
    logic [TAG_W:0]     num_busy;
    logic               ret_idle_err;

    modport master (
        output alloc_valid, alloc_rd, kill_valid, kill_tag, flush,
               ret_valid, ret_tag, ret_err, chk_rs1, chk_rs2,
        input  alloc_ready, alloc_tag, rs1_pend, rs2_pend,
               wb_valid, wb_rd, wb_tag, wb_err, num_busy, ret_idle_err
    );

    modport slave (
        input  alloc_valid, alloc_rd, kill_valid, kill_tag, flush,
               ret_valid, ret_tag, ret_err, chk_rs1, chk_rs2,
        output alloc_ready, alloc_tag, rs1_pend, rs2_pend,
               wb_valid, wb_rd, wb_tag, wb_err, num_busy, ret_idle_err
    );

endinterface

// File: rtl/swerv_nbload_cam_entry.sv
// One scoreboard entry: state/rd register with alloc > return > stale priority.
module swerv_nbload_cam_entry
    import swerv_nbload_cam_pkg::*;
(
    input  logic          clk,
    input  logic          rst_l,
    input  logic          alloc_hit,
    input  logic [4:0]    alloc_rd,
    input  logic          kill_hit,
    input  logic          ret_hit,
    output nbload_entry_t ent_q
);

    nbload_entry_t ent_d;

    // Return beats kill/flush/supersede: the bus response frees the slot.
    always_comb begin
        ent_d = ent_q;
        if (alloc_hit) begin
            ent_d.state = nb_alloc_state(alloc_rd);
            ent_d.rd    = alloc_rd;
        end else if (ret_hit) begin
            ent_d.state = NB_IDLE;
        end else if (kill_hit && ent_q.state == NB_PEND) begin
            ent_d.state = NB_STALE;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) ent_q <= '0;
        else        ent_q <= ent_d;
    end

endmodule

// File: rtl/swerv_nbload_cam.sv
// Outstanding non-blocking load scoreboard: tag allocation, rd hazards, writeback.
module swerv_nbload_cam
    import swerv_nbload_cam_pkg::*;
#(
    parameter int DEPTH = RV_LSU_NUM_NBLOAD,
    parameter int NWB   = 2
) (
    input  logic clk,
    input  logic rst_l,
    swerv_nbload_cam_if.slave bus
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    nbload_entry_t        ent [DEPTH];
    logic [DEPTH-1:0]     alloc_hit, kill_hit, ret_hit;
    logic                 any_free, alloc_fire;
    logic [TAG_W-1:0]     free_tag;

    logic [NWB-1:0]       wb_valid_d, wb_valid_q, wb_err_d, wb_err_q;
    logic [NWB*5-1:0]     wb_rd_d, wb_rd_q;
    logic [NWB*TAG_W-1:0] wb_tag_d, wb_tag_q;
    logic [CNT_W-1:0]     busy_d, busy_q;
    logic                 idle_err_d, idle_err_q;

    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!any_free && ent[i].state == NB_IDLE) begin
                any_free = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    assign alloc_fire = bus.alloc_valid && any_free;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            alloc_hit[i] = alloc_fire && (free_tag == TAG_W'(i));
            kill_hit[i]  = bus.flush
                        || (bus.kill_valid && bus.kill_tag == TAG_W'(i))
                        || (alloc_fire && bus.alloc_rd != 5'd0 && ent[i].rd == bus.alloc_rd);
            ret_hit[i]   = 1'b0;
            for (int unsigned c = 0; c < NWB; c++) begin
                if (bus.ret_valid[c] && bus.ret_tag[c*TAG_W +: TAG_W] == TAG_W'(i))
                    ret_hit[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        swerv_nbload_cam_entry u_ent (
            .clk       (clk),
            .rst_l     (rst_l),
            .alloc_hit (alloc_hit[g]),
            .alloc_rd  (bus.alloc_rd),
            .kill_hit  (kill_hit[g]),
            .ret_hit   (ret_hit[g]),
            .ent_q     (ent[g])
        );
    end

    // Writeback reflects the entry state before this edge's kill/flush.
    always_comb begin
        logic [TAG_W-1:0] rtag;
        logic [1:0]       hst;
        logic [4:0]       hrd;
        logic [CNT_W-1:0] frees;
        wb_valid_d = '0;
        wb_err_d   = '0;
        wb_rd_d    = wb_rd_q;
        wb_tag_d   = wb_tag_q;
        idle_err_d = idle_err_q;
        frees      = '0;
        for (int unsigned c = 0; c < NWB; c++) begin
            rtag = bus.ret_tag[c*TAG_W +: TAG_W];
            hst  = NB_IDLE;
            hrd  = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rtag == TAG_W'(i)) begin
                    hst = ent[i].state;
                    hrd = ent[i].rd;
                end
            end
            if (bus.ret_valid[c]) begin
                wb_rd_d[c*5 +: 5]         = hrd;
                wb_tag_d[c*TAG_W +: TAG_W] = rtag;
                if (hst == NB_PEND) begin
                    wb_valid_d[c] = !bus.ret_err[c];
                    wb_err_d[c]   = bus.ret_err[c];
                end
                if (hst == NB_IDLE) idle_err_d = 1'b1;
                else                frees = frees + CNT_W'(1);
            end
        end
        busy_d = busy_q + CNT_W'(alloc_fire) - frees;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wb_valid_q <= '0;
            wb_err_q   <= '0;
            wb_rd_q    <= '0;
            wb_tag_q   <= '0;
            busy_q     <= '0;
            idle_err_q <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_err_q   <= wb_err_d;
            wb_rd_q    <= wb_rd_d;
            wb_tag_q   <= wb_tag_d;
            busy_q     <= busy_d;
            idle_err_q <= idle_err_d;
        end
    end

    always_comb begin
        bus.rs1_pend = 1'b0;
        bus.rs2_pend = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent[i].state == NB_PEND && bus.chk_rs1 != 5'd0 && ent[i].rd == bus.chk_rs1)
                bus.rs1_pend = 1'b1;
            if (ent[i].state == NB_PEND && bus.chk_rs2 != 5'd0 && ent[i].rd == bus.chk_rs2)
                bus.rs2_pend = 1'b1;
        end
    end

    assign bus.alloc_ready  = any_free;
    assign bus.alloc_tag    = free_tag;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_err       = wb_err_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_tag       = wb_tag_q;
    assign bus.num_busy     = busy_q;
    assign bus.ret_idle_err = idle_err_q;

endmodule

// File: tb/tb_swerv_nbload_cam.sv
// Scoreboard bench for swerv_nbload_cam: directed scenarios plus random traffic.
module tb_swerv_nbload_cam;

    localparam int DEPTH = 4;
    localparam int NWB   = 2;
    localparam int TAG_W = 2;
    localparam int S_FREE  = 0;
    localparam int S_WRITE = 1;
    localparam int S_DROP  = 2;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    swerv_nbload_cam_if #(.DEPTH(DEPTH), .NWB(NWB)) bus();
    swerv_nbload_cam #(.DEPTH(DEPTH), .NWB(NWB)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rd;
        int tag;
        int err;
        int due;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int m_state[DEPTH];
    int m_rd[DEPTH];
    int m_idle_err;

    always @(posedge clk) begin
        if (rst_l)
            assert (!(bus.ret_valid[0] && bus.ret_valid[1] && bus.ret_tag[1:0] == bus.ret_tag[3:2]))
            else $error("illegal: both channels returned the same tag");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_first();
        for (int i = 0; i < DEPTH; i++) if (m_state[i] == S_FREE) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_state[i] = S_FREE;
            m_rd[i] = 0;
        end
        m_idle_err = 0;
        q0.delete();
        q1.delete();
    endtask

    // Monitor: pops the expected writeback whenever the DUT presents one.
    initial begin
        exp_t e;
        int have;
        bit fired;
        forever begin
            @(negedge clk);
            if (rst_l) begin
                for (int c = 0; c < NWB; c++) begin
                    fired = bus.wb_valid[c] || bus.wb_err[c];
                    have = (c == 0) ? q0.size() : q1.size();
                    if (fired) begin
                        if (have == 0) chk($sformatf("wb%0d_unexpected", c), 1, 0);
                        else begin
                            e = (c == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("wb%0d_cycle", c), cyc, e.due);
                            chk($sformatf("wb%0d_valid", c), int'(bus.wb_valid[c]), (e.err == 0) ? 1 : 0);
                            chk($sformatf("wb%0d_err", c), int'(bus.wb_err[c]), e.err);
                            chk($sformatf("wb%0d_rd", c), int'(bus.wb_rd[c*5 +: 5]), e.rd);
                            chk($sformatf("wb%0d_tag", c), int'(bus.wb_tag[c*TAG_W +: TAG_W]), e.tag);
                        end
                    end else if (have > 0) begin
                        e = (c == 0) ? q0[0] : q1[0];
                        if (e.due <= cyc) begin
                            if (c == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            chk($sformatf("wb%0d_missing", c), 0, 1);
                        end
                    end
                end
            end
        end
    end

    // Drive one cycle, check combinational outputs against the model, advance the model.
    task automatic step(input bit av, input int ard, input bit kv, input int kt, input bit fl,
                        input bit rv0, input int rt0, input bit re0,
                        input bit rv1, input int rt1, input bit re1,
                        input int rs1, input int rs2);
        int first, busy, p1, p2;
        int ns[DEPTH];
        bit fire, rv, re;
        int t;
        exp_t e;
        bus.alloc_valid = av;
        bus.alloc_rd    = 5'(ard);
        bus.kill_valid  = kv;
        bus.kill_tag    = TAG_W'(kt);
        bus.flush       = fl;
        bus.ret_valid   = {rv1, rv0};
        bus.ret_tag     = {TAG_W'(rt1), TAG_W'(rt0)};
        bus.ret_err     = {re1, re0};
        bus.chk_rs1     = 5'(rs1);
        bus.chk_rs2     = 5'(rs2);
        #1;
        first = m_first();
        busy = 0; p1 = 0; p2 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_state[i] != S_FREE) busy++;
            if (m_state[i] == S_WRITE && rs1 != 0 && m_rd[i] == rs1) p1 = 1;
            if (m_state[i] == S_WRITE && rs2 != 0 && m_rd[i] == rs2) p2 = 1;
        end
        chk("alloc_ready", int'(bus.alloc_ready), (first >= 0) ? 1 : 0);
        if (first >= 0) chk("alloc_tag", int'(bus.alloc_tag), first);
        chk("num_busy", int'(bus.num_busy), busy);
        chk("rs1_pend", int'(bus.rs1_pend), p1);
        chk("rs2_pend", int'(bus.rs2_pend), p2);
        chk("ret_idle_err", int'(bus.ret_idle_err), m_idle_err);

        ns = m_state;
        fire = av && (first >= 0);
        for (int c = 0; c < NWB; c++) begin
            rv = (c == 0) ? rv0 : rv1;
            t  = (c == 0) ? rt0 : rt1;
            re = (c == 0) ? re0 : re1;
            if (rv) begin
                if (m_state[t] == S_FREE) m_idle_err = 1;
                else begin
                    if (m_state[t] == S_WRITE) begin
                        e.rd = m_rd[t]; e.tag = t; e.err = re; e.due = cyc + 1;
                        if (c == 0) q0.push_back(e);
                        else        q1.push_back(e);
                    end
                    ns[t] = S_FREE;
                end
            end
        end
        if (kv && ns[kt] == S_WRITE) ns[kt] = S_DROP;
        for (int i = 0; i < DEPTH; i++)
            if (ns[i] == S_WRITE && (fl || (fire && ard != 0 && m_rd[i] == ard))) ns[i] = S_DROP;
        if (fire) begin
            ns[first] = (ard == 0) ? S_DROP : S_WRITE;
            m_rd[first] = ard;
        end
        m_state = ns;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic alloc(input int rd);
        step(1, rd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ret(input int ch, input int tag, input bit err);
        if (ch == 0) step(0, 0, 0, 0, 0, 1, tag, err, 0, 0, 0, 0, 0);
        else         step(0, 0, 0, 0, 0, 0, 0, 0, 1, tag, err, 0, 0);
    endtask

    task automatic reset_mid();
        #2;
        rst_l = 1'b0;
        #1;
        chk("rst_wb_valid", int'(bus.wb_valid), 0);
        chk("rst_wb_err", int'(bus.wb_err), 0);
        chk("rst_wb_rd", int'(bus.wb_rd), 0);
        chk("rst_wb_tag", int'(bus.wb_tag), 0);
        chk("rst_num_busy", int'(bus.num_busy), 0);
        chk("rst_alloc_ready", int'(bus.alloc_ready), 1);
        chk("rst_alloc_tag", int'(bus.alloc_tag), 0);
        chk("rst_idle_err", int'(bus.ret_idle_err), 0);
        model_reset();
        bus.alloc_valid = 1'b0; bus.kill_valid = 1'b0; bus.flush = 1'b0; bus.ret_valid = '0;
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        int first, rt0, rt1;
        bit av, rv0, rv1;
        int ard;
        bus.alloc_valid = 1'b0; bus.alloc_rd = '0; bus.kill_valid = 1'b0; bus.kill_tag = '0;
        bus.flush = 1'b0; bus.ret_valid = '0; bus.ret_tag = '0; bus.ret_err = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("por_alloc_ready", int'(bus.alloc_ready), 1);
        chk("por_alloc_tag", int'(bus.alloc_tag), 0);
        chk("por_num_busy", int'(bus.num_busy), 0);
        chk("por_wb_valid", int'(bus.wb_valid), 0);
        @(negedge clk);
        rst_l = 1'b1;

        // Fill, then drain on both channels.
        alloc(5); alloc(6); alloc(7); alloc(8);
        idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2, 0, 1, 3, 1, 0, 0);
        idle();
        // Single load round trip.
        alloc(5); ret(0, 0, 0); idle(); idle();
        // Same-rd supersede.
        alloc(9); alloc(9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        ret(0, 0, 0); ret(1, 1, 0); idle();
        // Flush concurrent with an allocation.
        alloc(1); alloc(2); alloc(4);
        step(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 0, 0);
        idle();
        // Kill racing a return, then a return to an IDLE tag.
        alloc(11); alloc(12);
        step(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 12, 11);
        ret(0, 2, 0); idle();
        ret(1, 0, 0); idle();
        // Reset with loads in flight and a writeback on the bus.
        alloc(20); alloc(21); alloc(22); alloc(23);
        ret(0, 0, 0);
        chk("pre_rst_wb_valid", int'(bus.wb_valid[0]), 1);
        reset_mid();
        idle();

        for (int n = 0; n < 600; n++) begin
            first = m_first();
            av  = ($urandom % 3) != 0;
            ard = $urandom % 8;
            rv0 = ($urandom % 10) < 4;
            rt0 = $urandom % DEPTH;
            if (m_state[rt0] == S_FREE && (($urandom % 20) != 0 || (av && rt0 == first))) rv0 = 1'b0;
            rv1 = ($urandom % 10) < 4;
            rt1 = $urandom % DEPTH;
            if (m_state[rt1] == S_FREE && (($urandom % 20) != 0 || (av && rt1 == first))) rv1 = 1'b0;
            if (rv0 && rt1 == rt0) rv1 = 1'b0;
            step(av, ard, ($urandom % 6) == 0, $urandom % DEPTH, ($urandom % 25) == 0,
                 rv0, rt0, ($urandom % 5) == 0, rv1, rt1, ($urandom % 5) == 0,
                 $urandom % 8, $urandom % 8);
            if (n == 300) reset_mid();
        end
        idle(); idle();
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
